// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
// The alignment check is kept here so the data-side fetch can reuse it.
package inst_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } fetch_state_t;

  function automatic logic addr_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Signals between the fetch stage and its PC stage, decode stage and instruction memory.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic              pc_valid;
  logic [ADDR_W-1:0] pc_addr;
  logic              fetch_stall;
  logic              flush;
  logic              id_stall;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [INST_W-1:0] inst_rdata;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_adel;

  modport slave (
    input  pc_valid, pc_addr, flush, id_stall, inst_addr_ok, inst_data_ok, inst_rdata,
    output fetch_stall, inst_req, inst_addr, id_valid, id_pc, id_inst, id_adel
  );

  modport master (
    output pc_valid, pc_addr, flush, id_stall, inst_addr_ok, inst_data_ok, inst_rdata,
    input  fetch_stall, inst_req, inst_addr, id_valid, id_pc, id_inst, id_adel
  );

endinterface

// File: rtl/inst_fetch_slot.sv
// One-entry output register toward decode.
// Priority on the valid bit: flush, then load, then consume.
module inst_fetch_slot
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_adel,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_adel
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_adel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
      r_adel  <= 1'b0;
    end else begin
      if (i_flush)      r_valid <= 1'b0;
      else if (i_load)  r_valid <= 1'b1;
      else if (!i_stall) r_valid <= 1'b0;

      if (i_load && !i_flush) begin
        r_pc   <= i_pc;
        r_inst <= i_inst;
        r_adel <= i_adel;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_adel  = r_adel;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: takes PCs from the PC stage, runs one outstanding memory
// transaction at a time, and parks each result in a one-entry slot for decode.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.slave  bus
);

  fetch_state_t      r_state, w_state_nxt;
  logic              r_inst_req, w_inst_req_nxt;
  logic [ADDR_W-1:0] r_inst_addr, w_inst_addr_nxt;
  logic              r_discard, w_discard_nxt;

  logic              w_id_valid;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_load;
  logic [ADDR_W-1:0] w_load_pc;
  logic [INST_W-1:0] w_load_inst;
  logic              w_load_adel;

  assign w_slot_free = !w_id_valid || !bus.id_stall;
  assign w_accept    = (r_state == S_IDLE) && bus.pc_valid && !bus.flush && w_slot_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_inst_req  <= 1'b0;
      r_inst_addr <= '0;
      r_discard   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_inst_req  <= w_inst_req_nxt;
      r_inst_addr <= w_inst_addr_nxt;
      r_discard   <= w_discard_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_inst_req_nxt  = r_inst_req;
    w_inst_addr_nxt = r_inst_addr;
    w_discard_nxt   = r_discard;
    w_load          = 1'b0;
    w_load_pc       = r_inst_addr;
    w_load_inst     = bus.inst_rdata;
    w_load_adel     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Misaligned PCs never reach memory; the error rides the slot instead.
          if (!addr_aligned(bus.pc_addr[1:0])) begin
            w_load      = 1'b1;
            w_load_pc   = bus.pc_addr;
            w_load_inst = '0;
            w_load_adel = 1'b1;
          end else begin
            w_inst_addr_nxt = bus.pc_addr;
            w_inst_req_nxt  = 1'b1;
            w_state_nxt     = S_REQ;
          end
        end
      end
      S_REQ: begin
        // The request stays up through a flush; only its response is dropped.
        if (bus.inst_addr_ok) begin
          w_inst_req_nxt = 1'b0;
          w_state_nxt    = S_RESP;
        end
        if (bus.flush) w_discard_nxt = 1'b1;
      end
      S_RESP: begin
        if (bus.inst_data_ok) begin
          w_state_nxt   = S_IDLE;
          w_discard_nxt = 1'b0;
          if (!r_discard && !bus.flush) w_load = 1'b1;
        end else if (bus.flush) begin
          w_discard_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  inst_fetch_slot u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.flush),
    .i_stall (bus.id_stall),
    .i_load  (w_load),
    .i_pc    (w_load_pc),
    .i_inst  (w_load_inst),
    .i_adel  (w_load_adel),
    .o_valid (w_id_valid),
    .o_pc    (bus.id_pc),
    .o_inst  (bus.id_inst),
    .o_adel  (bus.id_adel)
  );

  assign bus.id_valid    = w_id_valid;
  assign bus.fetch_stall = !bus.flush && !((r_state == S_IDLE) && w_slot_free);
  assign bus.inst_req    = r_inst_req;
  assign bus.inst_addr   = r_inst_addr;

  a_data_ok_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
    bus.inst_data_ok |-> (r_state == S_RESP));
  a_addr_ok_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    bus.inst_addr_ok |-> (r_state == S_REQ));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: one task per scenario, expected values written by hand.
module tb_inst_fetch;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  inst_fetch_if bus ();

  inst_fetch u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pc_valid     = 1'b0;
    bus.pc_addr      = '0;
    bus.flush        = 1'b0;
    bus.id_stall     = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
  endtask

  // Zero-wait fetch; returns one tick after the slot loads.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
    bus.pc_valid = 1'b1;
    bus.pc_addr  = pc;
    step();
    bus.pc_valid     = 1'b0;
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = data;
    step();
    bus.inst_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.inst_req); end
    n_tests++; if (bus.inst_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.inst_addr); end
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.id_valid); end
    n_tests++; if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 || bus.id_adel !== 1'b0) begin
      n_fail++; $display("FAIL reset_slot: got pc=%h inst=%h adel=%b expected zeros", bus.id_pc, bus.id_inst, bus.id_adel); end
    n_tests++; if (bus.fetch_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.fetch_stall); end
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'hBFC0_0000;
    #1;
    n_tests++; if (bus.fetch_stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall_idle: got %b expected 0", bus.fetch_stall); end
    step();
    bus.pc_valid = 1'b0;
    #1;
    n_tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0000) begin
      n_fail++; $display("FAIL basic_req: got req=%b addr=%h expected 1 bfc00000", bus.inst_req, bus.inst_addr); end
    n_tests++; if (bus.fetch_stall !== 1'b1) begin n_fail++; $display("FAIL basic_stall_req: got %b expected 1", bus.fetch_stall); end
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h3C08_0001;
    #1;
    n_tests++; if (bus.inst_req !== 1'b0 || bus.fetch_stall !== 1'b1 || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_resp: got req=%b stall=%b valid=%b expected 0 1 0", bus.inst_req, bus.fetch_stall, bus.id_valid); end
    step();
    bus.inst_data_ok = 1'b0;
    n_tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hBFC0_0000 || bus.id_inst !== 32'h3C08_0001 || bus.id_adel !== 1'b0) begin
      n_fail++; $display("FAIL basic_slot: got v=%b pc=%h inst=%h adel=%b expected 1 bfc00000 3c080001 0",
                         bus.id_valid, bus.id_pc, bus.id_inst, bus.id_adel); end
    step();
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume: got %b expected 0", bus.id_valid); end
  endtask

  task automatic test_slow_mem();
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'hBFC0_0004;
    step();
    bus.pc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0004) begin
        n_fail++; $display("FAIL slow_req_hold%0d: got req=%b addr=%h expected 1 bfc00004", i, bus.inst_req, bus.inst_addr); end
      step();
    end
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus.id_valid !== 1'b0 || bus.inst_req !== 1'b0) begin
        n_fail++; $display("FAIL slow_wait%0d: got valid=%b req=%b expected 0 0", i, bus.id_valid, bus.inst_req); end
    end
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h8C09_0004;
    step();
    bus.inst_data_ok = 1'b0;
    n_tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hBFC0_0004 || bus.id_inst !== 32'h8C09_0004) begin
      n_fail++; $display("FAIL slow_slot: got v=%b pc=%h inst=%h expected 1 bfc00004 8c090004", bus.id_valid, bus.id_pc, bus.id_inst); end
    step();
    n_tests++; if (bus.id_valid !== 1'b0 || bus.fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL slow_no_dup: got valid=%b stall=%b expected 0 0", bus.id_valid, bus.fetch_stall); end
  endtask

  task automatic test_flush_resp();
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'hBFC0_0008;
    step();
    bus.pc_valid     = 1'b0;
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok = 1'b0;
    bus.flush        = 1'b1;
    bus.pc_valid     = 1'b1;
    bus.pc_addr      = 32'hBFC0_0100;
    #1;
    n_tests++; if (bus.fetch_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", bus.fetch_stall); end
    step();
    bus.flush        = 1'b0;
    bus.pc_valid     = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_BEEF;
    step();
    bus.inst_data_ok = 1'b0;
    n_tests++; if (bus.id_valid !== 1'b0 || bus.inst_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_resp_drop: got valid=%b req=%b expected 0 0", bus.id_valid, bus.inst_req); end
    do_fetch(32'hBFC0_0380, 32'h2402_0001);
    n_tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hBFC0_0380 || bus.id_inst !== 32'h2402_0001) begin
      n_fail++; $display("FAIL flush_resp_next: got v=%b pc=%h inst=%h expected 1 bfc00380 24020001", bus.id_valid, bus.id_pc, bus.id_inst); end
    step();
  endtask

  task automatic test_flush_req();
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'hBFC0_0010;
    step();
    bus.pc_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    n_tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0010) begin
      n_fail++; $display("FAIL flush_req_hold: got req=%b addr=%h expected 1 bfc00010", bus.inst_req, bus.inst_addr); end
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h1111_1111;
    step();
    bus.inst_data_ok = 1'b0;
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_drop: got %b expected 0", bus.id_valid); end
    // Flush on the same cycle as the response.
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'hBFC0_0020;
    step();
    bus.pc_valid     = 1'b0;
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.flush        = 1'b1;
    bus.inst_rdata   = 32'h2222_2222;
    step();
    bus.inst_data_ok = 1'b0;
    bus.flush        = 1'b0;
    n_tests++; if (bus.id_valid !== 1'b0 || bus.fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_coincide: got valid=%b stall=%b expected 0 0", bus.id_valid, bus.fetch_stall); end
    do_fetch(32'hBFC0_0024, 32'h3333_3333);
    n_tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hBFC0_0024 || bus.id_inst !== 32'h3333_3333) begin
      n_fail++; $display("FAIL flush_discard_clear: got v=%b pc=%h inst=%h expected 1 bfc00024 33333333", bus.id_valid, bus.id_pc, bus.id_inst); end
    step();
  endtask

  task automatic test_decode_stall();
    do_fetch(32'hBFC0_0040, 32'hAAAA_0001);
    bus.id_stall = 1'b1;
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'hBFC0_0044;
    #1;
    n_tests++; if (bus.fetch_stall !== 1'b1) begin n_fail++; $display("FAIL stall_back: got %b expected 1", bus.fetch_stall); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++; if (bus.inst_req !== 1'b0 || bus.id_valid !== 1'b1 || bus.id_inst !== 32'hAAAA_0001 || bus.id_pc !== 32'hBFC0_0040) begin
        n_fail++; $display("FAIL stall_hold%0d: got req=%b v=%b pc=%h inst=%h expected 0 1 bfc00040 aaaa0001",
                           i, bus.inst_req, bus.id_valid, bus.id_pc, bus.id_inst); end
    end
    bus.id_stall = 1'b0;
    #1;
    n_tests++; if (bus.fetch_stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b expected 0", bus.fetch_stall); end
    step();
    bus.pc_valid = 1'b0;
    n_tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0044 || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_next_req: got req=%b addr=%h v=%b expected 1 bfc00044 0", bus.inst_req, bus.inst_addr, bus.id_valid); end
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hAAAA_0002;
    step();
    bus.inst_data_ok = 1'b0;
    n_tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hBFC0_0044 || bus.id_inst !== 32'hAAAA_0002) begin
      n_fail++; $display("FAIL stall_next_slot: got v=%b pc=%h inst=%h expected 1 bfc00044 aaaa0002", bus.id_valid, bus.id_pc, bus.id_inst); end
    step();
  endtask

  task automatic test_misaligned_and_reset();
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'hBFC0_0002;
    step();
    n_tests++; if (bus.inst_req !== 1'b0 || bus.id_valid !== 1'b1 || bus.id_adel !== 1'b1 ||
                   bus.id_inst !== 32'h0 || bus.id_pc !== 32'hBFC0_0002) begin
      n_fail++; $display("FAIL adel_slot: got req=%b v=%b adel=%b inst=%h pc=%h expected 0 1 1 0 bfc00002",
                         bus.inst_req, bus.id_valid, bus.id_adel, bus.id_inst, bus.id_pc); end
    // Back-to-back load and consume keeps the slot valid with new contents.
    bus.pc_addr = 32'hBFC0_0005;
    step();
    bus.pc_valid = 1'b0;
    n_tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hBFC0_0005 || bus.inst_req !== 1'b0) begin
      n_fail++; $display("FAIL adel_b2b: got v=%b pc=%h req=%b expected 1 bfc00005 0", bus.id_valid, bus.id_pc, bus.inst_req); end
    step();
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL adel_consume: got %b expected 0", bus.id_valid); end
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'hBFC0_0200;
    step();
    bus.pc_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.inst_req !== 1'b0 || bus.inst_addr !== 32'h0 || bus.id_valid !== 1'b0 ||
                   bus.id_pc !== 32'h0 || bus.id_adel !== 1'b0 || bus.fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got req=%b addr=%h v=%b pc=%h adel=%b stall=%b expected all 0",
                         bus.inst_req, bus.inst_addr, bus.id_valid, bus.id_pc, bus.id_adel, bus.fetch_stall); end
    #2 rst_n = 1'b1;
    step();
    n_tests++; if (bus.inst_req !== 1'b0 || bus.fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got req=%b stall=%b expected 0 0", bus.inst_req, bus.fetch_stall); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_slow_mem();
    test_flush_resp();
    test_flush_req();
    test_decode_stall();
    test_misaligned_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
